aap_decode: RTL and testbench
=============================

# aap_decode

Decode stage of the AAP pipeline, directly downstream of instruction fetch. Consumes the 16-bit instruction words fetch produces, each tagged with its PC. Assembles 16-bit and 32-bit (two-word) instructions and splits them into class, opcode and register fields. Presents one registered decoded instruction per handshake to the execute stage.

## Interface
- `PC_W`, default 10: program-counter width, matching the fetch PC.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `flush`  in  1: synchronous pipeline flush on branch redirect.
- `fetch_valid`  in  1: `fetch_word` and `fetch_pc` are valid.
- `fetch_word`  in  16: instruction word.
- `fetch_pc`  in  PC_W: address of `fetch_word`.
- `fetch_ready`  out  1: decode accepts a word this cycle.
- `dec_valid`  out  1: decoded instruction is valid.
- `dec_ready`  in  1: execute accepts the decoded instruction.
- `dec_pc`  out  PC_W: PC of the first word of the instruction.
- `dec_insn`  out  32: raw instruction, as {hi word, lo word}; short instructions have hi = 0.
- `dec_long`  out  1: instruction is 32-bit.
- `dec_class`  out  4: {hi[14:13], lo[14:13]}.
- `dec_opcode`  out  8: {hi[12:9], lo[12:9]}.
- `dec_rd`, `dec_ra`, `dec_rb`  out  6 each: {hi[8:6], lo[8:6]}, {hi[5:3], lo[5:3]}, {hi[2:0], lo[2:0]}.
- `dec_err`  out  1: the second word of a long instruction had bit 15 set.

## Operation
- Word transfer occurs when `fetch_valid & fetch_ready`. Output transfer occurs when `dec_valid & dec_ready`.
- `fetch_ready = ~flush & (~dec_valid | dec_ready)`. This rule is uniform in both states.
- FSM states:
  - LO: awaiting the first word.
  - HI: low word held, awaiting the second word.
- LO, word accepted with bit 15 = 0: load the output register (long = 0, hi = 0, err = 0) and stay in LO.
- LO, word accepted with bit 15 = 1: latch the lo word and its PC, then go to HI. The output register is not written.
- HI, word accepted: load the output register from the latched lo word, the new hi word and the latched PC (long = 1, err = hi[15]). Return to LO. `fetch_pc` of the hi word is ignored.
- Output register:
  - `dec_valid` is set on load.
  - It is cleared on an output transfer with no simultaneous load.
  - If a transfer and a load occur in the same cycle, `dec_valid` stays 1 with the new contents.
- While `dec_valid & ~dec_ready`, all `dec_*` outputs hold stable.
- `flush` has priority over everything:
  - Next state is LO, `dec_valid` goes to 0, and any latched lo word is discarded.
  - No word is accepted in the flush cycle.
- `dec_err` is informational only; the instruction is still delivered.

## Timing
- Reset (async) state:
  - State is LO and `dec_valid` = 0.
  - All `dec_*` data outputs are 0, and `dec_pc` is 0.
  - `fetch_ready` is 1 once reset deasserts.
- Latency:
  - Short instruction accepted at edge N: `dec_valid` is high after edge N.
  - Long instruction: valid after the edge that accepts the hi word.
- Throughput: one short instruction per cycle with `dec_ready` held at 1. Long instructions take two cycles.
- Bubbles between the lo and hi words (`fetch_valid` = 0 in HI) are allowed; the state holds indefinitely.
- Reset or flush in HI drops the partial instruction. The next accepted word is treated as a lo word.

## Structure
- Shared package `aap_pkg` holds:
  - The decode field bit positions (LONG_BIT = 15, CLASS, OPCODE, RD, RA, RB ranges).
  - The state encoding localparams LO and HI.
  - The WORD_W = 16 constant.
- Sub-module `aap_field_split`: combinational {hi, lo} → class/opcode/rd/ra/rb splitter, reusable by the disassembler and trace monitors. The FSM and output register stay in `aap_decode`.

## Test plan
- Short word, with `dec_ready` = 1:
  - Stimulus: 0x1234 at PC 0x005.
  - Required response: next cycle `dec_valid` = 1, `dec_long` = 0, `dec_class` = 0, `dec_opcode` = 0x09, `rd` = 0, `ra` = 6, `rb` = 4, `dec_pc` = 0x005, `dec_insn` = 0x00001234.
- Long instruction:
  - Stimulus: 0x8A49 at PC 0x010, then 0x0249 with one bubble between them.
  - Required response: one output with `dec_long` = 1, `dec_insn` = 0x02498A49, `dec_opcode` = 0x15, `rd` = `ra` = `rb` = 9, `dec_pc` = 0x010, `dec_err` = 0.
- Stall:
  - Stimulus: 3 short words streamed while `dec_ready` = 0 for 4 cycles.
  - Required response: `fetch_ready` falls after the first load, the outputs hold the first instruction, and the three instructions emerge in order once `dec_ready` rises.
- Flush in HI:
  - Stimulus: 0x8A49 accepted, then `flush` asserted, then 0x1234.
  - Required response: no long instruction is emitted, `fetch_ready` = 0 in the flush cycle, and the output is the short 0x1234.
- Error flag:
  - Stimulus: 0x8A49, then 0x8249.
  - Required response: the instruction is delivered with `dec_err` = 1 and `dec_insn` = 0x82498A49.
- Async reset:
  - Stimulus: `reset` asserted mid-cycle while `dec_valid` = 1.
  - Required response: `dec_valid` and all data outputs go to 0 immediately without a clock edge, and the FSM returns to LO.

Source files
------------

// File: rtl/aap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aap_pkg
// Description : Shared constants for the AAP decode stage: instruction word
//               width, decode field bit positions and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package aap_pkg;

    localparam int WORD_W   = 16;

    // Bit 15 of a first word marks a 32-bit instruction; on a second word
    // it is illegal and raises the error flag.
    localparam int LONG_BIT = 15;

    localparam int CLASS_HI = 14;
    localparam int CLASS_LO = 13;
    localparam int OPC_HI   = 12;
    localparam int OPC_LO   = 9;
    localparam int RD_HI    = 8;
    localparam int RD_LO    = 6;
    localparam int RA_HI    = 5;
    localparam int RA_LO    = 3;
    localparam int RB_HI    = 2;
    localparam int RB_LO    = 0;

    // State encoding: LO awaits a first word, HI holds a lo word and
    // awaits its second word.
    localparam logic [0:0] LO = 1'b0;
    localparam logic [0:0] HI = 1'b1;

    typedef enum logic [0:0] {
        S_LO = LO,
        S_HI = HI
    } state_t;

endpackage : aap_pkg
`default_nettype wire

// File: rtl/aap_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : aap_decode_if
// Description : Fetch-side and execute-side handshakes of the decode stage.
//               master : fetch/execute environment (drives words, dec_ready)
//               slave  : decode stage (drives fetch_ready and dec_* outputs)
// Revision    : 1.0 - initial release
// ============================================================================
interface aap_decode_if #(
    parameter int PC_W = 10
);
    // fetch -> decode
    logic            fetch_valid;
    logic [15:0]     fetch_word;
    logic [PC_W-1:0] fetch_pc;
    logic            fetch_ready;
    // decode -> execute
    logic            dec_valid;
    logic            dec_ready;
    logic [PC_W-1:0] dec_pc;
    logic [31:0]     dec_insn;
    logic            dec_long;
    logic [3:0]      dec_class;
    logic [7:0]      dec_opcode;
    logic [5:0]      dec_rd;
    logic [5:0]      dec_ra;
    logic [5:0]      dec_rb;
    logic            dec_err;

    modport master (
        output fetch_valid, fetch_word, fetch_pc, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, dec_insn, dec_long,
               dec_class, dec_opcode, dec_rd, dec_ra, dec_rb, dec_err
    );

    modport slave (
        input  fetch_valid, fetch_word, fetch_pc, dec_ready,
        output fetch_ready, dec_valid, dec_pc, dec_insn, dec_long,
               dec_class, dec_opcode, dec_rd, dec_ra, dec_rb, dec_err
    );

endinterface : aap_decode_if
`default_nettype wire

// File: rtl/aap_field_split.sv
`default_nettype none
// ============================================================================
// Module      : aap_field_split
// Description : Combinational splitter of an AAP instruction {hi, lo} into
//               class/opcode/register fields plus the long and error flags.
//               A short instruction is presented with hi = 0.
// Ports       : hi_i, lo_i           - instruction words
//               class_o, opcode_o    - {hi field, lo field}
//               rd_o, ra_o, rb_o     - {hi field, lo field}
//               long_o               - lo word carries the long marker
//               err_o                - hi word carries a stray long marker
// Revision    : 1.0 - initial release
// ============================================================================
module aap_field_split
    import aap_pkg::*;
(
    input  wire logic [WORD_W-1:0] hi_i,
    input  wire logic [WORD_W-1:0] lo_i,
    output logic [3:0]             class_o,
    output logic [7:0]             opcode_o,
    output logic [5:0]             rd_o,
    output logic [5:0]             ra_o,
    output logic [5:0]             rb_o,
    output logic                   long_o,
    output logic                   err_o
);

    assign class_o  = {hi_i[CLASS_HI:CLASS_LO], lo_i[CLASS_HI:CLASS_LO]};
    assign opcode_o = {hi_i[OPC_HI:OPC_LO],     lo_i[OPC_HI:OPC_LO]};
    assign rd_o     = {hi_i[RD_HI:RD_LO],       lo_i[RD_HI:RD_LO]};
    assign ra_o     = {hi_i[RA_HI:RA_LO],       lo_i[RA_HI:RA_LO]};
    assign rb_o     = {hi_i[RB_HI:RB_LO],       lo_i[RB_HI:RB_LO]};

    // Short instructions always have a clear lo marker and a zero hi word,
    // so both flags fall out of the raw bits directly.
    assign long_o   = lo_i[LONG_BIT];
    assign err_o    = hi_i[LONG_BIT];

endmodule : aap_field_split
`default_nettype wire

// File: rtl/aap_decode.sv
`default_nettype none
// ============================================================================
// Module      : aap_decode
// Description : AAP decode stage. Assembles 16/32-bit instructions from the
//               fetch word stream and presents one registered decoded
//               instruction per handshake to execute.
// Ports       : clock  - rising-edge clock
//               reset  - asynchronous active-high reset
//               flush  - synchronous flush on branch redirect
//               bus    - aap_decode_if.slave (fetch in, decoded out)
// Revision    : 1.0 - initial release
// ============================================================================
module aap_decode
    import aap_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  wire logic     clock,
    input  wire logic     reset,
    input  wire logic     flush,
    aap_decode_if.slave   bus
);

    state_t                state_q,  state_d;
    logic [WORD_W-1:0]     lo_q,     lo_d;
    logic [PC_W-1:0]       lopc_q,   lopc_d;
    logic [2*WORD_W-1:0]   insn_q,   insn_d;
    logic [PC_W-1:0]       pc_q,     pc_d;
    logic                  valid_q,  valid_d;

    logic                  fetch_ready;
    logic                  accept;
    logic                  load;

    // Same ready rule in both states: a word is only taken when the output
    // register is free or draining this cycle, so a long instruction's hi
    // word can always be loaded straight into the output register.
    assign fetch_ready     = ~flush & (~valid_q | bus.dec_ready);
    assign accept          = bus.fetch_valid & fetch_ready;
    assign bus.fetch_ready = fetch_ready;

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        lopc_d  = lopc_q;
        insn_d  = insn_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        load    = 1'b0;

        if (flush) begin
            // fetch_ready is low here, so no word can be in flight.
            state_d = S_LO;
            lo_d    = '0;
            lopc_d  = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_LO: begin
                    if (accept) begin
                        if (bus.fetch_word[LONG_BIT]) begin
                            lo_d    = bus.fetch_word;
                            lopc_d  = bus.fetch_pc;
                            state_d = S_HI;
                        end else begin
                            load    = 1'b1;
                            insn_d  = {{WORD_W{1'b0}}, bus.fetch_word};
                            pc_d    = bus.fetch_pc;
                        end
                    end
                end
                S_HI: begin
                    if (accept) begin
                        // PC of the hi word is irrelevant; the instruction
                        // is addressed by its first word.
                        load    = 1'b1;
                        insn_d  = {bus.fetch_word, lo_q};
                        pc_d    = lopc_q;
                        state_d = S_LO;
                    end
                end
                default: state_d = S_LO;
            endcase

            if (load) begin
                valid_d = 1'b1;
            end else if (valid_q & bus.dec_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_LO;
            lo_q    <= '0;
            lopc_q  <= '0;
            insn_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            lopc_q  <= lopc_d;
            insn_q  <= insn_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.dec_valid = valid_q;
    assign bus.dec_pc    = pc_q;
    assign bus.dec_insn  = insn_q;

    // Fields are derived from the registered instruction, so they hold
    // stable exactly as long as the output register does.
    aap_field_split u_split (
        .hi_i     (insn_q[2*WORD_W-1:WORD_W]),
        .lo_i     (insn_q[WORD_W-1:0]),
        .class_o  (bus.dec_class),
        .opcode_o (bus.dec_opcode),
        .rd_o     (bus.dec_rd),
        .ra_o     (bus.dec_ra),
        .rb_o     (bus.dec_rb),
        .long_o   (bus.dec_long),
        .err_o    (bus.dec_err)
    );

endmodule : aap_decode
`default_nettype wire

// File: tb/tb_aap_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_aap_decode
// Description : Directed self-checking bench for aap_decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aap_decode;

    localparam int PC_W = 10;

    logic clock;
    logic reset;
    logic flush;

    int vectors     = 0;
    int miscompares = 0;

    aap_decode_if #(.PC_W(PC_W)) bus ();

    aap_decode #(.PC_W(PC_W)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] w, input logic [PC_W-1:0] pc);
        bus.fetch_valid = v;
        bus.fetch_word  = w;
        bus.fetch_pc    = pc;
    endtask

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        bus.dec_ready  = 1'b1;
        drive(1'b0, 16'h0000, '0);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid",  {31'd0, bus.dec_valid}, 32'd0);
        chk("rst_insn",   bus.dec_insn,           32'd0);
        chk("rst_pc",     {22'd0, bus.dec_pc},    32'd0);
        chk("rst_opcode", {24'd0, bus.dec_opcode}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);

        // ---------------- short word ----------------
        drive(1'b1, 16'h1234, 10'h005);
        step();
        drive(1'b0, 16'h0000, '0);
        chk("short_valid",  {31'd0, bus.dec_valid},  32'd1);
        chk("short_long",   {31'd0, bus.dec_long},   32'd0);
        chk("short_class",  {28'd0, bus.dec_class},  32'd0);
        chk("short_opcode", {24'd0, bus.dec_opcode}, 32'h09);
        chk("short_rd",     {26'd0, bus.dec_rd},     32'd0);
        chk("short_ra",     {26'd0, bus.dec_ra},     32'd6);
        chk("short_rb",     {26'd0, bus.dec_rb},     32'd4);
        chk("short_pc",     {22'd0, bus.dec_pc},     32'h005);
        chk("short_insn",   bus.dec_insn,            32'h0000_1234);
        chk("short_err",    {31'd0, bus.dec_err},    32'd0);
        step();
        chk("short_drain",  {31'd0, bus.dec_valid},  32'd0);

        // ---------------- long instruction with a bubble ----------------
        drive(1'b1, 16'h8A49, 10'h010);
        step();
        drive(1'b0, 16'h0000, '0);
        chk("long_lo_novalid", {31'd0, bus.dec_valid}, 32'd0);
        step();
        chk("long_bubble_novalid", {31'd0, bus.dec_valid}, 32'd0);
        drive(1'b1, 16'h0249, 10'h3FF);
        step();
        drive(1'b0, 16'h0000, '0);
        chk("long_valid",  {31'd0, bus.dec_valid},  32'd1);
        chk("long_long",   {31'd0, bus.dec_long},   32'd1);
        chk("long_insn",   bus.dec_insn,            32'h0249_8A49);
        chk("long_opcode", {24'd0, bus.dec_opcode}, 32'h15);
        chk("long_rd",     {26'd0, bus.dec_rd},     32'd9);
        chk("long_ra",     {26'd0, bus.dec_ra},     32'd9);
        chk("long_rb",     {26'd0, bus.dec_rb},     32'd9);
        chk("long_pc",     {22'd0, bus.dec_pc},     32'h010);
        chk("long_err",    {31'd0, bus.dec_err},    32'd0);
        step();
        chk("long_single", {31'd0, bus.dec_valid},  32'd0);

        // ---------------- stall: 3 words, dec_ready low 4 cycles ----------------
        bus.dec_ready = 1'b0;
        drive(1'b1, 16'h0001, 10'h020);
        #1;
        chk("stall_ready_pre", {31'd0, bus.fetch_ready}, 32'd1);
        step();
        drive(1'b1, 16'h0002, 10'h021);
        chk("stall_valid",      {31'd0, bus.dec_valid},   32'd1);
        chk("stall_ready_fall", {31'd0, bus.fetch_ready}, 32'd0);
        chk("stall_insn0",      bus.dec_insn,             32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_insn",  bus.dec_insn,             32'h0000_0001);
            chk("stall_hold_pc",    {22'd0, bus.dec_pc},      32'h020);
            chk("stall_hold_ready", {31'd0, bus.fetch_ready}, 32'd0);
        end
        bus.dec_ready = 1'b1;
        #1;
        chk("stall_ready_rise", {31'd0, bus.fetch_ready}, 32'd1);
        chk("stall_out0",       bus.dec_insn,             32'h0000_0001);
        step();
        drive(1'b1, 16'h0003, 10'h022);
        chk("stall_out1",       bus.dec_insn,             32'h0000_0002);
        chk("stall_out1_valid", {31'd0, bus.dec_valid},   32'd1);
        step();
        drive(1'b0, 16'h0000, '0);
        chk("stall_out2",       bus.dec_insn,             32'h0000_0003);
        chk("stall_out2_pc",    {22'd0, bus.dec_pc},      32'h022);
        step();
        chk("stall_drain",      {31'd0, bus.dec_valid},   32'd0);

        // ---------------- flush in HI ----------------
        drive(1'b1, 16'h8A49, 10'h030);
        step();
        flush = 1'b1;
        drive(1'b1, 16'h1234, 10'h040);
        #1;
        chk("flush_ready", {31'd0, bus.fetch_ready}, 32'd0);
        step();
        flush = 1'b0;
        chk("flush_novalid", {31'd0, bus.dec_valid}, 32'd0);
        step();
        drive(1'b0, 16'h0000, '0);
        chk("flush_valid", {31'd0, bus.dec_valid}, 32'd1);
        chk("flush_long",  {31'd0, bus.dec_long},  32'd0);
        chk("flush_insn",  bus.dec_insn,           32'h0000_1234);
        chk("flush_pc",    {22'd0, bus.dec_pc},    32'h040);
        step();
        chk("flush_drain", {31'd0, bus.dec_valid}, 32'd0);

        // ---------------- error flag ----------------
        drive(1'b1, 16'h8A49, 10'h050);
        step();
        drive(1'b1, 16'h8249, 10'h051);
        step();
        drive(1'b0, 16'h0000, '0);
        bus.dec_ready = 1'b0;
        chk("err_valid", {31'd0, bus.dec_valid}, 32'd1);
        chk("err_long",  {31'd0, bus.dec_long},  32'd1);
        chk("err_flag",  {31'd0, bus.dec_err},   32'd1);
        chk("err_insn",  bus.dec_insn,           32'h8249_8A49);
        chk("err_pc",    {22'd0, bus.dec_pc},    32'h050);

        // ---------------- async reset mid-cycle with dec_valid = 1 ----------------
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid",  {31'd0, bus.dec_valid},  32'd0);
        chk("arst_insn",   bus.dec_insn,            32'd0);
        chk("arst_pc",     {22'd0, bus.dec_pc},     32'd0);
        chk("arst_long",   {31'd0, bus.dec_long},   32'd0);
        chk("arst_err",    {31'd0, bus.dec_err},    32'd0);
        chk("arst_opcode", {24'd0, bus.dec_opcode}, 32'd0);
        reset = 1'b0;
        bus.dec_ready = 1'b1;
        #1;
        chk("arst_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);

        // ---------------- async reset while in HI drops the lo word ----------------
        drive(1'b1, 16'h8A49, 10'h070);
        step();
        drive(1'b0, 16'h0000, '0);
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        drive(1'b1, 16'h1234, 10'h071);
        step();
        drive(1'b0, 16'h0000, '0);
        chk("hirst_valid", {31'd0, bus.dec_valid}, 32'd1);
        chk("hirst_long",  {31'd0, bus.dec_long},  32'd0);
        chk("hirst_insn",  bus.dec_insn,           32'h0000_1234);
        chk("hirst_pc",    {22'd0, bus.dec_pc},    32'h071);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_aap_decode
`default_nettype wire
